// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master; the hazard controller is the slave.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 4,
   parameter int PERF_W     = 32
);
   logic [REG_ADDR_W-1:0] rs1_id;
   logic [REG_ADDR_W-1:0] rs2_id;
   logic                  rs1Used_id;
   logic                  rs2Used_id;
   logic [REG_ADDR_W-1:0] rd_exe;
   logic                  memRead_exe;
   logic                  branchTaken_exe;
   logic                  mcStart_exe;
   logic [CNT_W-1:0]      mcLen_exe;
   logic                  dmemBusy;
   logic                  stall_if;
   logic                  stall_id;
   logic                  stall_exe;
   logic                  flush_if_id;
   logic                  flush_id_exe;
   logic                  busy_o;
   logic [PERF_W-1:0]     stallCycles_o;
   logic [PERF_W-1:0]     flushCount_o;

   modport master (
      output rs1_id, rs2_id, rs1Used_id, rs2Used_id, rd_exe, memRead_exe,
             branchTaken_exe, mcStart_exe, mcLen_exe, dmemBusy,
      input  stall_if, stall_id, stall_exe, flush_if_id, flush_id_exe,
             busy_o, stallCycles_o, flushCount_o
   );

   modport slave (
      input  rs1_id, rs2_id, rs1Used_id, rs2Used_id, rd_exe, memRead_exe,
             branchTaken_exe, mcStart_exe, mcLen_exe, dmemBusy,
      output stall_if, stall_id, stall_exe, flush_if_id, flush_id_exe,
             busy_o, stallCycles_o, flushCount_o
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use, taken branches,
// multi-cycle EXE operations and data-memory back-pressure, with perf counters.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 4,
   parameter int PERF_W     = 32
) (
   input logic clk,
   input logic rst,
   pipeline_hazard_ctrl_if.slave hz
);

   typedef enum logic [0:0] {RUN, MCBUSY} state_t;

   state_t            state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic [PERF_W-1:0] stallCycles, flushCount;
   logic              loadUse, mcGo;
   logic              stallIf, stallId, stallExe, flushIfId, flushIdExe;

   assign loadUse = hz.memRead_exe && (hz.rd_exe != '0) &&
                    ((hz.rs1Used_id && (hz.rs1_id == hz.rd_exe)) ||
                     (hz.rs2Used_id && (hz.rs2_id == hz.rd_exe)));

   // A zero-length multi-cycle request is treated as no request at all.
   assign mcGo = hz.mcStart_exe && (hz.mcLen_exe != '0);

   // Priority chain: reset, memory busy, multi-cycle busy, branch, mc start, load-use.
   always_comb begin
      stallIf    = 1'b0;
      stallId    = 1'b0;
      stallExe   = 1'b0;
      flushIfId  = 1'b0;
      flushIdExe = 1'b0;
      stateNext  = state;
      cntNext    = cnt;
      if (rst) begin
         stateNext = RUN;
         cntNext   = '0;
      end else if (hz.dmemBusy) begin
         stallIf  = 1'b1;
         stallId  = 1'b1;
         stallExe = 1'b1;
      end else if (state == MCBUSY) begin
         stallIf  = 1'b1;
         stallId  = 1'b1;
         stallExe = 1'b1;
         if (cnt == CNT_W'(1)) begin
            stateNext = RUN;
            cntNext   = '0;
         end else begin
            cntNext = cnt - CNT_W'(1);
         end
      end else if (hz.branchTaken_exe) begin
         flushIfId  = 1'b1;
         flushIdExe = 1'b1;
      end else if (mcGo) begin
         stallIf   = 1'b1;
         stallId   = 1'b1;
         stallExe  = 1'b1;
         cntNext   = hz.mcLen_exe - CNT_W'(1);
         stateNext = (hz.mcLen_exe >= CNT_W'(2)) ? MCBUSY : RUN;
      end else if (loadUse) begin
         stallIf    = 1'b1;
         stallId    = 1'b1;
         flushIdExe = 1'b1;
      end
   end

   // State, down-counter and saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         cnt         <= '0;
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (stallIf && (stallCycles != {PERF_W{1'b1}})) begin
            stallCycles <= stallCycles + PERF_W'(1);
         end
         if (flushIfId && (flushCount != {PERF_W{1'b1}})) begin
            flushCount <= flushCount + PERF_W'(1);
         end
      end
   end

   assign hz.stall_if      = stallIf;
   assign hz.stall_id      = stallId;
   assign hz.stall_exe     = stallExe;
   assign hz.flush_if_id   = flushIfId;
   assign hz.flush_id_exe  = flushIdExe;
   assign hz.busy_o        = (state == MCBUSY) && !rst;
   assign hz.stallCycles_o = stallCycles;
   assign hz.flushCount_o  = flushCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: single-cycle vector table plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_pipeline_hazard_ctrl;

   typedef struct {
      string      name;
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       mcs;
      logic [3:0] mcl;
      logic       db;
      logic [5:0] exp;
   } vec_t;

   typedef struct {
      string      name;
      logic       rst;
      logic [5:0] exp;
   } expEntry_t;

   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   longint expStall;
   longint expFlush;
   expEntry_t expQ[$];
   vec_t table_[];

   pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4), .PERF_W(32)) hz ();

   pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4), .PERF_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a vector; exp bits are {stall_if, stall_id, stall_exe, flush_if_id, flush_id_exe, busy_o}.
   function automatic vec_t mk(input string name, input logic r, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr, input logic br,
                               input logic mcs, input logic [3:0] mcl, input logic db,
                               input logic [5:0] exp);
      vec_t v;
      v.name = name; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
      v.rd = rd; v.mr = mr; v.br = br; v.mcs = mcs; v.mcl = mcl; v.db = db; v.exp = exp;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      expEntry_t e;
      rst                = v.rst;
      hz.rs1_id          = v.rs1;
      hz.rs2_id          = v.rs2;
      hz.rs1Used_id      = v.u1;
      hz.rs2Used_id      = v.u2;
      hz.rd_exe          = v.rd;
      hz.memRead_exe     = v.mr;
      hz.branchTaken_exe = v.br;
      hz.mcStart_exe     = v.mcs;
      hz.mcLen_exe       = v.mcl;
      hz.dmemBusy        = v.db;
      e.name = v.name;
      e.rst  = v.rst;
      e.exp  = v.exp;
      expQ.push_back(e);
   endtask

   task automatic checkOutput();
      expEntry_t e;
      logic [5:0] got;
      if (expQ.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = expQ.pop_front();
      got = {hz.stall_if, hz.stall_id, hz.stall_exe, hz.flush_if_id, hz.flush_id_exe, hz.busy_o};
      compared++;
      if (got !== e.exp) begin
         mismatched++;
         $display("[TB] FAIL %s outputs: got %b expected %b", e.name, got, e.exp);
      end
      compared++;
      if (hz.stallCycles_o !== 32'(expStall)) begin
         mismatched++;
         $display("[TB] FAIL %s stallCycles: got %0d expected %0d", e.name, hz.stallCycles_o, expStall);
      end
      compared++;
      if (hz.flushCount_o !== 32'(expFlush)) begin
         mismatched++;
         $display("[TB] FAIL %s flushCount: got %0d expected %0d", e.name, hz.flushCount_o, expFlush);
      end
      // Advance the counter model by what this cycle should register at the next edge.
      if (e.rst) begin
         expStall = 0;
         expFlush = 0;
      end else begin
         expStall += longint'(e.exp[5]);
         expFlush += longint'(e.exp[2]);
      end
   endtask

   task automatic runCycle(input vec_t v);
      applyStimulus(v);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      expStall   = 0;
      expFlush   = 0;

      table_ = new[15];
      table_[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
      table_[1]  = mk("loadUseRs1",    0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 6'b110010);
      table_[2]  = mk("loadUseRd0",    0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 6'b000000);
      table_[3]  = mk("loadUseRs2",    0, 1, 9, 1, 1, 9, 1, 0, 0, 0, 0, 6'b110010);
      table_[4]  = mk("rs1NotUsed",    0, 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 6'b000000);
      table_[5]  = mk("noLoad",        0, 5, 5, 1, 1, 5, 0, 0, 0, 0, 0, 6'b000000);
      table_[6]  = mk("branchLoadUse", 0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 6'b000110);
      table_[7]  = mk("branchOnly",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b000110);
      table_[8]  = mk("mcLenZero",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000000);
      table_[9]  = mk("mcLenZeroLU",   0, 7, 0, 1, 0, 7, 1, 0, 1, 0, 0, 6'b110010);
      table_[10] = mk("mcLenOne",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111000);
      table_[11] = mk("mcLenOneLU",    0, 3, 0, 1, 0, 3, 1, 0, 1, 1, 0, 6'b111000);
      table_[12] = mk("branchOverMc",  0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 6'b000110);
      table_[13] = mk("dmemBusyRun",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 6'b111000);
      table_[14] = mk("rstGated",      1, 5, 0, 1, 0, 5, 1, 1, 1, 4, 1, 6'b000000);

      applyStimulus(mk("init", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
      void'(expQ.pop_front());
      @(posedge clk);
      #1;

      for (int i = 0; i < table_.size(); i++) begin
         runCycle(table_[i]);
      end

      // Four-cycle multi-cycle op: busy on cycles 2-4, and branch/load-use ignored while busy.
      runCycle(mk("mc4c1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 6'b111000));
      runCycle(mk("mc4c2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'b111001));
      runCycle(mk("mc4c3", 0, 5, 0, 1, 0, 5, 1, 0, 1, 2, 0, 6'b111001));
      runCycle(mk("mc4c4", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001));
      runCycle(mk("mc4c5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));

      // Memory back-pressure freezes the countdown at cnt=2.
      runCycle(mk("mc3start", 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 6'b111000));
      for (int i = 0; i < 3; i++) begin
         runCycle(mk("mc3dmem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b111001));
      end
      runCycle(mk("mc3rel1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001));
      runCycle(mk("mc3rel2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001));
      runCycle(mk("mc3done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));

      // Reset in the middle of a long op aborts it.
      runCycle(mk("mc5start", 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 6'b111000));
      runCycle(mk("mc5busy",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b111001));
      runCycle(mk("mc5rst1",  1, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 6'b000000));
      runCycle(mk("mc5rst2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000));
      runCycle(mk("postRst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
      runCycle(mk("postRstLU", 0, 4, 0, 1, 0, 4, 1, 0, 0, 0, 0, 6'b110010));
      runCycle(mk("postRstIdle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 4, multi-cycle length and counter width.
- PERF_W, 32, performance-counter width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset; synchronous and active-high.
- rs1_id, in, REG_ADDR_W, source-1 index of the instruction in ID.
- rs2_id, in, REG_ADDR_W, source-2 index of the instruction in ID.
- rs1Used_id, in, 1, ID instruction reads rs1.
- rs2Used_id, in, 1, ID instruction reads rs2.
- rd_exe, in, REG_ADDR_W, destination index of the instruction in EXE.
- memRead_exe, in, 1, EXE instruction is a load.
- branchTaken_exe, in, 1, EXE resolved a taken branch or jump.
- mcStart_exe, in, 1, EXE starts a multi-cycle ALU operation.
- mcLen_exe, in, CNT_W, total EXE-occupancy cycles of that operation.
- dmemBusy, in, 1, data memory not ready.
- stall_if, out, 1, hold PC and IF/ID.
- stall_id, out, 1, hold ID/EXE (drives the ID/EXE register stall).
- stall_exe, out, 1, hold EXE/MEM.
- flush_if_id, out, 1, load a bubble into IF/ID.
- flush_id_exe, out, 1, load a bubble into ID/EXE.
- busy_o, out, 1, state is MCBUSY.
- stallCycles_o, out, PERF_W, count of cycles with stall_if=1.
- flushCount_o, out, PERF_W, count of cycles with flush_if_id=1.

Function
REQ-003 The block SHALL have two states, RUN and MCBUSY, plus a CNT_W-bit down-counter cnt.
REQ-004 The block SHALL compute loadUse = memRead_exe & (rd_exe!=0) & ((rs1Used_id & rs1_id==rd_exe) | (rs2Used_id & rs2_id==rd_exe)).
REQ-005 Outputs SHALL be combinational from state and inputs, evaluated in the priority order of REQ-006 through REQ-010, with the first matching rule winning.
REQ-006 dmemBusy=1, any state: stall_if=stall_id=stall_exe=1, both flushes=0, state and cnt hold.
REQ-007 MCBUSY (dmemBusy=0):
- stall_if=stall_id=stall_exe=1; flushes=0.
- branchTaken_exe, loadUse and mcStart_exe are ignored.
- If cnt==1: next state RUN, cnt<=0; else cnt<=cnt-1.
REQ-008 RUN, branchTaken_exe=1: flush_if_id=flush_id_exe=1, all stalls=0, state stays RUN.
REQ-009 RUN, mcStart_exe=1 and mcLen_exe>=1:
- stall_if=stall_id=stall_exe=1 this cycle; cnt<=mcLen_exe-1.
- Next state MCBUSY if mcLen_exe>=2, else RUN.
- Total stall = mcLen_exe cycles when dmemBusy stays 0.
- mcLen_exe=0 SHALL be treated as mcStart_exe=0.
REQ-010 RUN, loadUse=1: stall_if=stall_id=1, flush_id_exe=1, stall_exe=0, flush_if_id=0; exactly one cycle, no state change.
REQ-011 RUN with no rule active: all stall and flush outputs SHALL be 0.
REQ-012 busy_o SHALL equal (state==MCBUSY).
REQ-013 stallCycles_o SHALL increment by 1 on each cycle where stall_if=1, and flushCount_o on each cycle where flush_if_id=1; both SHALL saturate at all-ones.

Reset
REQ-014 With rst=1 at a rising edge: state<=RUN, cnt<=0, both performance counters<=0.
REQ-015 While rst=1, all stall and flush outputs and busy_o SHALL be 0, regardless of other inputs.
REQ-016 Reset asserted during MCBUSY SHALL abort the operation; RUN applies from the next edge.

Verification
REQ-017 Load-use: memRead_exe=1, rd_exe=5, rs1_id=5, rs1Used_id=1 -> one cycle of stall_if=stall_id=flush_id_exe=1 and stall_exe=0; stallCycles_o +1.
REQ-018 Same as REQ-017 but rd_exe=0 -> no stall and no flush.
REQ-019 mcStart_exe=1, mcLen_exe=4 -> stalls high exactly 4 cycles; busy_o high cycles 2-4; RUN on cycle 5.
REQ-020 branchTaken_exe=1 together with loadUse=1 in RUN -> both flushes=1, stalls=0; flushCount_o +1.
REQ-021 MCBUSY with cnt=2, dmemBusy=1 for 3 cycles -> cnt holds at 2; after release, 2 more stall cycles, then RUN.
REQ-022 rst=1 mid-MCBUSY -> outputs 0 during reset; counters read 0 and state is RUN after release.
